// File: rtl/rc5_pkg.sv
// RC5 shared types, magic constants and W-parametrised rotate helpers.
package rc5_pkg;

    typedef enum logic {ENC = 1'b0, DEC = 1'b1} mode_e;

    typedef enum logic [2:0] {
        B_IDLE, B_PRE, B_ROUND, B_POST, B_DONE
    } blk_state_e;

    typedef enum logic [1:0] {
        KIDLE, KLOAD, KINIT, KMIX
    } key_state_e;

    function automatic logic [31:0] magic_p(input int w);
        return (w == 16) ? 32'h0000_B7E1 : 32'hB7E1_5163;
    endfunction

    function automatic logic [31:0] magic_q(input int w);
        return (w == 16) ? 32'h0000_9E37 : 32'h9E37_79B9;
    endfunction

    // Shifts of >= operand width give zero, so s == 0 needs no special case.
    function automatic logic [31:0] rotl(input logic [31:0] x,
                                         input logic [4:0] s,
                                         input int w);
        if (w == 16)
            return {16'h0, (x[15:0] << s[3:0]) |
                           (x[15:0] >> (5'd16 - {1'b0, s[3:0]}))};
        return (x << s) | (x >> (6'd32 - {1'b0, s}));
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x,
                                         input logic [4:0] s,
                                         input int w);
        if (w == 16)
            return {16'h0, (x[15:0] >> s[3:0]) |
                           (x[15:0] << (5'd16 - {1'b0, s[3:0]}))};
        return (x >> s) | (x << (6'd32 - {1'b0, s}));
    endfunction

endpackage

// File: rtl/rc5_key_sched.sv
// RC5 key expansion: owns the L words and the S table, one mix step per cycle.
module rc5_key_sched
    import rc5_pkg::*;
#(
    parameter int W          = 32,
    parameter int KEY_BYTES  = 16,
    parameter int MAX_ROUNDS = 20,
    localparam int RW        = $clog2(MAX_ROUNDS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [RW-1:0]          rounds,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [RW-1:0]          rd_idx,
    output logic                   busy,
    output logic                   valid,
    output logic [RW-1:0]          r_cur,
    output logic [W-1:0]           s_even,
    output logic [W-1:0]           s_odd
);

    localparam int C     = (8 * KEY_BYTES + W - 1) / W;
    localparam int CW    = (C > 1) ? $clog2(C) : 1;
    localparam int SW    = RW + 1;
    localparam int T_MAX = 2 * MAX_ROUNDS + 2;
    localparam int KPW   = C * W;
    localparam logic [31:0] P32 = magic_p(W);
    localparam logic [31:0] Q32 = magic_q(W);
    localparam logic [W-1:0] P  = P32[W-1:0];
    localparam logic [W-1:0] Q  = Q32[W-1:0];

    function automatic logic [W-1:0] rl(input logic [W-1:0] x,
                                        input logic [W-1:0] s);
        return W'(rotl(32'(x), s[4:0], W));
    endfunction

    key_state_e             state;
    logic [W-1:0]           s_tab [T_MAX];
    logic [W-1:0]           l_tab [C];
    logic [8*KEY_BYTES-1:0] key_q;
    logic [RW-1:0]          r_q;
    logic [SW-1:0]          i;
    logic [CW-1:0]          j;
    logic [9:0]             cnt;
    logic [W-1:0]           a;
    logic [W-1:0]           b;

    logic [SW-1:0]  tl;
    logic [9:0]     t_n;
    logic [9:0]     m_n;
    logic [9:0]     mix_last;
    logic [KPW-1:0] key_pad;
    logic [W-1:0]   a_mix;
    logic [W-1:0]   ab;
    logic [W-1:0]   b_mix;

    // tl is the last S index, 2r+1; mix runs 3*max(T,C) steps.
    assign tl       = {r_q, 1'b1};
    assign t_n      = 10'(tl) + 10'd1;
    assign m_n      = (t_n > 10'(C)) ? t_n : 10'(C);
    assign mix_last = (m_n << 1) + m_n - 10'd1;
    assign key_pad  = KPW'(key_q);
    assign a_mix    = rl(s_tab[i] + a + b, W'(3));
    assign ab       = a_mix + b;
    assign b_mix    = rl(l_tab[j] + ab, ab);

    assign r_cur  = r_q;
    assign s_even = s_tab[{rd_idx, 1'b0}];
    assign s_odd  = s_tab[{rd_idx, 1'b1}];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= KIDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
            r_q   <= '0;
            i     <= '0;
            j     <= '0;
            cnt   <= '0;
            a     <= '0;
            b     <= '0;
        end else begin
            unique case (state)
                KIDLE: begin
                    if (start) begin
                        key_q <= key;
                        r_q   <= rounds;
                        busy  <= 1'b1;
                        valid <= 1'b0;
                        state <= KLOAD;
                    end
                end
                KLOAD: begin
                    a     <= P;
                    i     <= '0;
                    state <= KINIT;
                end
                KINIT: begin
                    a <= a + Q;
                    i <= i + SW'(1);
                    if (i == tl) begin
                        i     <= '0;
                        j     <= '0;
                        a     <= '0;
                        b     <= '0;
                        cnt   <= '0;
                        state <= KMIX;
                    end
                end
                KMIX: begin
                    a   <= a_mix;
                    b   <= b_mix;
                    i   <= (i == tl) ? '0 : i + SW'(1);
                    j   <= (j == CW'(C - 1)) ? '0 : j + CW'(1);
                    cnt <= cnt + 10'd1;
                    if (cnt == mix_last) begin
                        busy  <= 1'b0;
                        valid <= 1'b1;
                        state <= KIDLE;
                    end
                end
                default: state <= KIDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        unique case (state)
            KLOAD: begin
                for (int w = 0; w < C; w++)
                    l_tab[w] <= key_pad[w*W +: W];
            end
            KINIT: s_tab[i] <= a;
            KMIX: begin
                s_tab[i] <= a_mix;
                l_tab[j] <= b_mix;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rc5_engine.sv
// RC5-W/r/b block engine: block FSM with valid/ready handshakes over a cached key.
module rc5_engine
    import rc5_pkg::*;
#(
    parameter int W          = 32,
    parameter int KEY_BYTES  = 16,
    parameter int MAX_ROUNDS = 20,
    localparam int RW        = $clog2(MAX_ROUNDS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_load,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [RW-1:0]          num_rounds,
    output logic                   key_busy,
    output logic                   key_valid,
    output logic                   key_err,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [2*W-1:0]         d_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*W-1:0]         d_out
);

    function automatic logic [W-1:0] rl(input logic [W-1:0] x,
                                        input logic [W-1:0] s);
        return W'(rotl(32'(x), s[4:0], W));
    endfunction

    function automatic logic [W-1:0] rr(input logic [W-1:0] x,
                                        input logic [W-1:0] s);
        return W'(rotr(32'(x), s[4:0], W));
    endfunction

    blk_state_e    state;
    mode_e         mode;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [RW-1:0] rnd;

    logic [RW-1:0] rd_idx;
    logic [RW-1:0] r_cur;
    logic [RW-1:0] rnd_last;
    logic [W-1:0]  s_even;
    logic [W-1:0]  s_odd;
    logic          key_ok;
    logic [W-1:0]  ea;
    logic [W-1:0]  eb;
    logic [W-1:0]  da;
    logic [W-1:0]  db;

    rc5_key_sched #(
        .W          (W),
        .KEY_BYTES  (KEY_BYTES),
        .MAX_ROUNDS (MAX_ROUNDS)
    ) u_ks (
        .clk    (clk),
        .rst    (rst),
        .start  (key_ok),
        .rounds (num_rounds),
        .key    (key),
        .rd_idx (rd_idx),
        .busy   (key_busy),
        .valid  (key_valid),
        .r_cur  (r_cur),
        .s_even (s_even),
        .s_odd  (s_odd)
    );

    assign in_ready = key_valid && state == B_IDLE && !key_busy && !out_valid;

    // A block handshake in the same cycle wins over a key reload.
    assign key_ok = key_load && state == B_IDLE && !out_valid && !key_busy
                 && num_rounds != '0 && num_rounds <= RW'(MAX_ROUNDS)
                 && !(in_valid && in_ready);

    assign rd_idx   = (state == B_ROUND) ? rnd : '0;
    assign rnd_last = (mode == ENC) ? r_cur : RW'(1);

    assign ea = rl(a ^ b, b) + s_even;
    assign eb = rl(b ^ ea, ea) + s_odd;
    assign db = rr(b - s_odd, a) ^ a;
    assign da = rr(a - s_even, db) ^ db;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= B_IDLE;
            mode      <= ENC;
            a         <= '0;
            b         <= '0;
            rnd       <= '0;
            out_valid <= 1'b0;
            d_out     <= '0;
            key_err   <= 1'b0;
        end else begin
            key_err <= key_load && !key_ok;
            unique case (state)
                B_IDLE: begin
                    if (in_valid && in_ready) begin
                        a     <= d_in[W-1:0];
                        b     <= d_in[2*W-1:W];
                        mode  <= in_mode ? DEC : ENC;
                        state <= B_PRE;
                    end
                end
                B_PRE: begin
                    if (mode == ENC) begin
                        a <= a + s_even;
                        b <= b + s_odd;
                    end
                    rnd   <= (mode == ENC) ? RW'(1) : r_cur;
                    state <= B_ROUND;
                end
                B_ROUND: begin
                    a <= (mode == ENC) ? ea : da;
                    b <= (mode == ENC) ? eb : db;
                    if (rnd == rnd_last)
                        state <= B_POST;
                    else if (mode == ENC)
                        rnd <= rnd + RW'(1);
                    else
                        rnd <= rnd - RW'(1);
                end
                B_POST: begin
                    d_out     <= (mode == DEC) ? {b - s_odd, a - s_even}
                                               : {b, a};
                    out_valid <= 1'b1;
                    state     <= B_DONE;
                end
                B_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= B_IDLE;
                    end
                end
                default: state <= B_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_engine.sv
// Scoreboard bench for rc5_engine: RC5-32/12/16 KAT, handshakes, errors, W=16 roundtrip.
module tb_rc5_engine;

    localparam logic [63:0] KAT_CT = {32'h6D8F4B15, 32'hEEDBA521};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         key_load;
    logic [127:0] key;
    logic [4:0]   num_rounds;
    logic         key_busy;
    logic         key_valid;
    logic         key_err;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [63:0]  d_in;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  d_out;

    logic         key_load_h;
    logic [127:0] key_h;
    logic [4:0]   num_rounds_h;
    logic         key_busy_h;
    logic         key_valid_h;
    logic         key_err_h;
    logic         in_valid_h;
    logic         in_ready_h;
    logic         in_mode_h;
    logic [31:0]  d_in_h;
    logic         out_valid_h;
    logic         out_ready_h;
    logic [31:0]  d_out_h;

    int n_pass  = 0;
    int n_total = 0;
    logic [63:0] sb[$];
    logic [31:0] sb16[$];

    rc5_engine dut (
        .clk(clk), .rst(rst), .key_load(key_load), .key(key),
        .num_rounds(num_rounds), .key_busy(key_busy), .key_valid(key_valid),
        .key_err(key_err), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .d_in(d_in), .out_valid(out_valid),
        .out_ready(out_ready), .d_out(d_out)
    );

    rc5_engine #(.W(16), .KEY_BYTES(16), .MAX_ROUNDS(20)) dut16 (
        .clk(clk), .rst(rst), .key_load(key_load_h), .key(key_h),
        .num_rounds(num_rounds_h), .key_busy(key_busy_h),
        .key_valid(key_valid_h), .key_err(key_err_h),
        .in_valid(in_valid_h), .in_ready(in_ready_h), .in_mode(in_mode_h),
        .d_in(d_in_h), .out_valid(out_valid_h), .out_ready(out_ready_h),
        .d_out(d_out_h)
    );

    task automatic load32(input logic [127:0] k, input logic [4:0] r,
                          output int bc, output logic v1, output logic err);
        @(negedge clk);
        key = k; num_rounds = r; key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        err = key_err;
        bc = 0;
        while (key_busy && bc < 2000) begin
            bc++;
            @(posedge clk); #1;
        end
        v1 = key_valid;
    endtask

    task automatic run32(input logic m, input logic [63:0] din,
                         output logic [63:0] dout, output int lat);
        int n;
        lat = -1; dout = 'x; n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        in_valid = 1'b1; in_mode = m; d_in = din;
        @(posedge clk); #1;
        in_valid = 1'b0; in_mode = ~m; d_in = {$urandom, $urandom};
        n = 1;
        while (!out_valid && n < 300) begin @(posedge clk); #1; n++; end
        if (out_valid) begin lat = n; dout = d_out; end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic run16(input logic m, input logic [31:0] din,
                         output logic [31:0] dout, output int lat);
        int n;
        lat = -1; dout = 'x; n = 0;
        @(negedge clk);
        while (!in_ready_h && n < 300) begin @(negedge clk); n++; end
        in_valid_h = 1'b1; in_mode_h = m; d_in_h = din;
        @(posedge clk); #1;
        in_valid_h = 1'b0; in_mode_h = ~m; d_in_h = $urandom;
        n = 1;
        while (!out_valid_h && n < 300) begin @(posedge clk); #1; n++; end
        if (out_valid_h) begin lat = n; dout = d_out_h; end
        @(negedge clk); out_ready_h = 1'b1;
        @(posedge clk); #1; out_ready_h = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_load = 0; key = '0; num_rounds = '0; in_valid = 0;
        in_mode = 0; d_in = '0; out_ready = 0;
        key_load_h = 0; key_h = '0; num_rounds_h = '0; in_valid_h = 0;
        in_mode_h = 0; d_in_h = '0; out_ready_h = 0;
        repeat (3) @(posedge clk);
        #1;
        if (key_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", key_busy);
        else n_pass++;
        n_total++;
        if (key_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", key_valid);
        else n_pass++;
        n_total++;
        if (key_err !== 1'b0) $display("FAIL reset_err got %b want 0", key_err);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready);
        else n_pass++;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
        else n_pass++;
        n_total++;
        if (d_out !== 64'h0) $display("FAIL reset_d_out got %h want 0", d_out);
        else n_pass++;
        n_total++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_kat();
        int bc, lat;
        logic v1, err;
        logic [63:0] o, e;
        load32('0, 5'd12, bc, v1, err);
        if (bc !== 105) $display("FAIL kat_busy_cycles got %0d want 105", bc);
        else n_pass++;
        n_total++;
        if (v1 !== 1'b1) $display("FAIL kat_key_valid got %b want 1", v1);
        else n_pass++;
        n_total++;
        if (err !== 1'b0) $display("FAIL kat_key_err got %b want 0", err);
        else n_pass++;
        n_total++;
        sb.push_back(KAT_CT);
        run32(1'b0, 64'h0, o, lat);
        e = sb.pop_front();
        if (o !== e) $display("FAIL kat_encrypt got %h want %h", o, e);
        else n_pass++;
        n_total++;
        if (lat !== 15) $display("FAIL kat_enc_latency got %0d want 15", lat);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_decrypt();
        int lat;
        logic [63:0] o, e, pt, ct;
        sb.push_back(64'h0);
        run32(1'b1, KAT_CT, o, lat);
        e = sb.pop_front();
        if (o !== e) $display("FAIL kat_decrypt got %h want %h", o, e);
        else n_pass++;
        n_total++;
        if (lat !== 15) $display("FAIL kat_dec_latency got %0d want 15", lat);
        else n_pass++;
        n_total++;
        for (int k = 0; k < 4; k++) begin
            pt = {$urandom, $urandom};
            run32(1'b0, pt, ct, lat);
            sb.push_back(pt);
            run32(1'b1, ct, o, lat);
            e = sb.pop_front();
            if (o !== e) $display("FAIL roundtrip32_%0d got %h want %h", k, o, e);
            else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [63:0] hold, e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        in_valid = 1'b1; in_mode = 1'b0; d_in = 64'h0;
        sb.push_back(KAT_CT);
        @(posedge clk); #1;
        in_mode = 1'b1; d_in = KAT_CT;
        sb.push_back(64'h0);
        n = 1;
        while (!out_valid && n < 300) begin @(posedge clk); #1; n++; end
        if (n !== 15) $display("FAIL bp_latency got %0d want 15", n);
        else n_pass++;
        n_total++;
        hold = d_out;
        e = sb.pop_front();
        if (hold !== e) $display("FAIL bp_result got %h want %h", hold, e);
        else n_pass++;
        n_total++;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (d_out !== hold || out_valid !== 1'b1)
                $display("FAIL bp_hold_%0d got %h/%b want %h/1", c, d_out, out_valid, hold);
            else n_pass++;
            n_total++;
            if (in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d got %b want 0", c, in_ready);
            else n_pass++;
            n_total++;
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        if (out_valid !== 1'b0) $display("FAIL bp_release got %b want 0", out_valid);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL bp_ready_after got %b want 1", in_ready);
        else n_pass++;
        n_total++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 300) begin @(posedge clk); #1; n++; end
        e = sb.pop_front();
        if (n !== 15 || d_out !== e)
            $display("FAIL bp_second got %h lat %0d want %h lat 15", d_out, n, e);
        else n_pass++;
        n_total++;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_key_err();
        int bc, n;
        logic v1, err;
        logic [63:0] e;
        load32('1, 5'd0, bc, v1, err);
        if (err !== 1'b1 || v1 !== 1'b1 || bc !== 0)
            $display("FAIL err_r0 got err=%b valid=%b busy=%0d want 1 1 0", err, v1, bc);
        else n_pass++;
        n_total++;
        load32('1, 5'd21, bc, v1, err);
        if (err !== 1'b1 || v1 !== 1'b1 || bc !== 0)
            $display("FAIL err_r21 got err=%b valid=%b busy=%0d want 1 1 0", err, v1, bc);
        else n_pass++;
        n_total++;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        in_valid = 1'b1; in_mode = 1'b0; d_in = 64'h0;
        sb.push_back(KAT_CT);
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        key = '1; num_rounds = 5'd12; key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        if (key_err !== 1'b1 || key_busy !== 1'b0)
            $display("FAIL err_in_round got err=%b busy=%b want 1 0", key_err, key_busy);
        else n_pass++;
        n_total++;
        n = 3;
        while (!out_valid && n < 300) begin @(posedge clk); #1; n++; end
        e = sb.pop_front();
        if (d_out !== e || n !== 15)
            $display("FAIL err_block got %h lat %0d want %h lat 15", d_out, n, e);
        else n_pass++;
        n_total++;
        if (key_valid !== 1'b1) $display("FAIL err_key_kept got %b want 1", key_valid);
        else n_pass++;
        n_total++;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_rst_mid();
        int n, bc, lat;
        logic v1, err;
        logic [63:0] o, e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        in_valid = 1'b1; in_mode = 1'b0; d_in = 64'h1234;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        if (out_valid !== 1'b0 || key_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL rst_mid got ov=%b kv=%b ir=%b want 0 0 0",
                     out_valid, key_valid, in_ready);
        else n_pass++;
        n_total++;
        load32('0, 5'd12, bc, v1, err);
        if (bc !== 105 || v1 !== 1'b1)
            $display("FAIL rst_reload got busy=%0d valid=%b want 105 1", bc, v1);
        else n_pass++;
        n_total++;
        sb.push_back(KAT_CT);
        run32(1'b0, 64'h0, o, lat);
        e = sb.pop_front();
        if (o !== e || lat !== 15)
            $display("FAIL rst_recover got %h lat %0d want %h lat 15", o, lat, e);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_w16();
        int bc, lat, lat2;
        logic [31:0] din, ct, pt, e;
        @(negedge clk);
        key_h = {$urandom, $urandom, $urandom, $urandom};
        num_rounds_h = 5'd20; key_load_h = 1'b1;
        @(posedge clk); #1; key_load_h = 1'b0;
        bc = 0;
        while (key_busy_h && bc < 2000) begin bc++; @(posedge clk); #1; end
        if (bc !== 169 || key_valid_h !== 1'b1)
            $display("FAIL w16_keyload got busy=%0d valid=%b want 169 1", bc, key_valid_h);
        else n_pass++;
        n_total++;
        for (int i = 0; i < 1000; i++) begin
            din = 32'(i * 3413);
            run16(1'b0, din, ct, lat);
            sb16.push_back(din);
            run16(1'b1, ct, pt, lat2);
            e = sb16.pop_front();
            if (pt !== e || lat !== 23 || lat2 !== 23)
                $display("FAIL w16_roundtrip_%0d got %h lat %0d/%0d want %h lat 23",
                         i, pt, lat, lat2, e);
            else n_pass++;
            n_total++;
        end
    endtask

    initial begin
        test_reset();
        test_kat();
        test_decrypt();
        test_backpressure();
        test_key_err();
        test_rst_mid();
        test_w16();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
